digit_scan_ctrl: RTL

- Upstream driver for the 2-to-4 decoder (enable, a, b → y[3:0]) in the 4-digit display path.
- Time-multiplexes four digit positions: a prescaler sets slot length, the scan index is driven on {b,a}, and enable is gated with a blanking dead-time so the decoder never glitches between digits.
- A per-digit mask skips dark positions.

---
 rtl/digit_scan_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Scan controller feeding the 2-to-4 digit decoder: walks the digit index over
// fixed-length slots, skips masked digits and blanks enable at each slot start.
module digit_scan_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] digit_mask,
  output logic       enable,
  output logic       a,
  output logic       b,
  output logic       slot_start
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             enable_q, enable_d;
  logic             slot_start_q, slot_start_d;

  // First lit digit after cur in scan order; cur itself is tried last, and an
  // all-dark mask still steps forward by one.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = cur + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = cur + 2'(k);
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      enable_q     <= 1'b0;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      enable_q     <= enable_d;
      slot_start_q <= slot_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    enable_d     = 1'b0;
    slot_start_d = 1'b0;
    if (!run) begin
      // Dropping run beats a pending wrap, so the index is held.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_BLANK;
          cnt_d        = '0;
          slot_start_d = 1'b1;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = S_BLANK;
            cnt_d        = '0;
            slot_start_d = 1'b1;
            idx_d        = next_idx(idx_q, digit_mask);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == S_ON || cnt_q == BLANK_LAST) begin
              state_d  = S_ON;
              enable_d = digit_mask[idx_q];
            end
          end
        end
      endcase
    end
  end

  assign enable     = enable_q;
  assign a          = idx_q[0];
  assign b          = idx_q[1];
  assign slot_start = slot_start_q;

endmodule
